// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one memory port between an instruction-fetch
// requester and a load/store requester. Load/store is preferred, but after
// MAX_LS_STREAK consecutive load/store grants while fetch waits, fetch wins.
// One transaction outstanding at a time; a stuck transaction is aborted after
// TIMEOUT cycles without mem_ack.
module memory_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_LS_STREAK = 4,
  parameter int TIMEOUT       = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_ready,
  output logic              if_stall,
  output logic              ls_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              err
);

  localparam int SW = $clog2(MAX_LS_STREAK + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    IF_XFER,
    LS_XFER
  } state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   streak, streak_nxt;
  logic [TW-1:0]   tmo_cnt;
  logic            pick_ls, pick_if;
  logic            grant_ls, grant_if;
  logic            in_xfer, xfer_ack, xfer_tmo;

  assign in_xfer  = (state != IDLE);
  assign xfer_ack = in_xfer && mem_ack;
  assign xfer_tmo = in_xfer && !mem_ack && (tmo_cnt == TW'(TIMEOUT - 1));

  assign mem_req  = in_xfer;
  assign if_stall = if_req & ~if_ready;
  assign ls_stall = ls_req & ~ls_ready;

  // Arbitration: the winner is chosen from the raw requests; if the winner is
  // the requester whose ready is pulsing this cycle it is masked and nothing
  // is granted. Choosing first and masking second keeps the LS streak intact
  // across the one-cycle ready gap instead of handing fetch a free grant.
  always_comb begin
    pick_ls  = ls_req && (!if_req || (streak < SW'(MAX_LS_STREAK)));
    pick_if  = !pick_ls && if_req;
    grant_ls = (state == IDLE) && pick_ls && !ls_ready;
    grant_if = (state == IDLE) && pick_if && !if_ready;
  end

  // Next-state and streak bookkeeping.
  always_comb begin
    state_nxt  = state;
    streak_nxt = streak;
    case (state)
      IDLE: begin
        if (grant_ls) begin
          state_nxt  = LS_XFER;
          streak_nxt = (streak == SW'(MAX_LS_STREAK)) ? streak : streak + 1'b1;
        end else if (grant_if) begin
          state_nxt  = IF_XFER;
          streak_nxt = '0;
        end
      end
      IF_XFER, LS_XFER: begin
        if (xfer_ack || xfer_tmo) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and streak registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      streak <= '0;
    end else begin
      state  <= state_nxt;
      streak <= streak_nxt;
    end
  end

  // Timeout counter: cleared on grant, counts un-acked transfer cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
    end else if (grant_ls || grant_if) begin
      tmo_cnt <= '0;
    end else if (in_xfer && !mem_ack) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Latch the granted request so requester changes cannot disturb it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else if (grant_ls) begin
      mem_addr  <= ls_addr;
      mem_we    <= ls_we;
      mem_wdata <= ls_wdata;
    end else if (grant_if) begin
      mem_addr  <= if_addr;
      mem_we    <= 1'b0;
    end
  end

  // Completion: capture read data, pulse ready (and err on timeout).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_rdata <= '0;
      ls_rdata <= '0;
      if_ready <= 1'b0;
      ls_ready <= 1'b0;
      err      <= 1'b0;
    end else begin
      if_ready <= (state == IF_XFER) && (xfer_ack || xfer_tmo);
      ls_ready <= (state == LS_XFER) && (xfer_ack || xfer_tmo);
      err      <= xfer_tmo;
      if (xfer_ack && (state == IF_XFER)) if_rdata <= mem_rdata;
      if (xfer_ack && (state == LS_XFER) && !mem_we) ls_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed self-checking bench for memory_arbiter.
module tb_memory_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [31:0] ls_rdata;
  logic        ls_ready;
  logic        if_stall;
  logic        ls_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        err;

  int checks = 0;
  int errors = 0;

  memory_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .MAX_LS_STREAK(4),
    .TIMEOUT(255)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_rdata(ls_rdata), .ls_ready(ls_ready),
    .if_stall(if_stall), .ls_stall(ls_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reset sequence; returns at a falling edge with reset released.
  task automatic do_reset();
    reset = 1'b0;
    if_req = 0; if_addr = '0; ls_req = 0; ls_we = 0; ls_addr = '0; ls_wdata = '0;
    mem_rdata = '0; mem_ack = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({mem_req, mem_we, if_ready, ls_ready, err} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00000", {mem_req, mem_we, if_ready, ls_ready, err});
    end
    checks++;
    if ({mem_addr, mem_wdata, if_rdata, ls_rdata} !== 128'h0) begin
      errors++; $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, if_rdata, ls_rdata});
    end
  endtask

  task automatic test_fetch();
    do_reset();
    if_req = 1; if_addr = 32'h10;
    #1;
    checks++;
    if (if_stall !== 1'b1) begin errors++; $display("FAIL fetch_stall: got %b want 1", if_stall); end
    @(negedge clk);                       // cycle 1
    checks++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h10}) begin
      errors++; $display("FAIL fetch_mem: got req=%b we=%b addr=%h want 1 0 00000010", mem_req, mem_we, mem_addr);
    end
    mem_ack = 1; mem_rdata = 32'h00500093; if_req = 0;
    @(negedge clk);                       // cycle 2
    checks++;
    if ({if_ready, mem_req, if_rdata} !== {1'b1, 1'b0, 32'h00500093}) begin
      errors++; $display("FAIL fetch_done: got rdy=%b req=%b data=%h want 1 0 00500093", if_ready, mem_req, if_rdata);
    end
    mem_ack = 0;
    @(negedge clk);
    checks++;
    if (if_ready !== 1'b0) begin errors++; $display("FAIL fetch_pulse: got %b want 0", if_ready); end
  endtask

  task automatic test_load();
    do_reset();
    ls_req = 1; ls_we = 0; ls_addr = 32'h80;
    @(negedge clk);
    checks++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h80}) begin
      errors++; $display("FAIL load_mem: got req=%b we=%b addr=%h want 1 0 00000080", mem_req, mem_we, mem_addr);
    end
    mem_ack = 1; mem_rdata = 32'hCAFEF00D; ls_req = 0;
    @(negedge clk);
    checks++;
    if ({ls_ready, if_ready, ls_rdata} !== {1'b1, 1'b0, 32'hCAFEF00D}) begin
      errors++; $display("FAIL load_done: got lsr=%b ifr=%b data=%h want 1 0 cafef00d", ls_ready, if_ready, ls_rdata);
    end
    mem_ack = 0;
  endtask

  task automatic test_store();
    int pulses = 0;
    do_reset();
    ls_req = 1; ls_we = 1; ls_addr = 32'h200; ls_wdata = 32'hDEADBEEF;
    @(negedge clk);
    ls_req = 0; ls_we = 0; ls_addr = 32'h999; ls_wdata = 32'h11111111;
    mem_rdata = 32'h12345678;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h200, 32'hDEADBEEF}) begin
        errors++; $display("FAIL store_hold%0d: got req=%b we=%b addr=%h wd=%h want 1 1 00000200 deadbeef",
                           c, mem_req, mem_we, mem_addr, mem_wdata);
      end
      if (c == 3) mem_ack = 1;
      @(negedge clk);
      if (ls_ready) pulses++;
    end
    mem_ack = 0;
    checks++;
    if ({ls_ready, mem_req, ls_rdata} !== {1'b1, 1'b0, 32'h0}) begin
      errors++; $display("FAIL store_done: got rdy=%b req=%b rdata=%h want 1 0 00000000", ls_ready, mem_req, ls_rdata);
    end
    repeat (3) begin
      @(negedge clk);
      if (ls_ready) pulses++;
    end
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL store_pulses: got %0d want 1", pulses); end
  endtask

  task automatic test_contention();
    logic [31:0] seq[$];
    logic [31:0] exp_seq[6];
    bit if_seen = 0;
    exp_seq = '{32'h300, 32'h300, 32'h300, 32'h300, 32'h100, 32'h300};
    do_reset();
    if_req = 1; if_addr = 32'h100; ls_req = 1; ls_we = 0; ls_addr = 32'h300; mem_ack = 1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (mem_req) seq.push_back(mem_addr);
      if (!if_seen) begin
        checks++;
        if (if_stall !== 1'b1) begin errors++; $display("FAIL cont_stall%0d: got %b want 1", c, if_stall); end
      end
      if (mem_req && mem_addr == 32'h100) if_seen = 1;
    end
    if_req = 0; ls_req = 0; mem_ack = 0;
    checks++;
    if (seq.size() < 6) begin
      errors++; $display("FAIL cont_count: got %0d grants want >=6", seq.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (seq[i] !== exp_seq[i]) begin
          errors++; $display("FAIL cont_grant%0d: got %h want %h", i, seq[i], exp_seq[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int n_req = 0;
    int n_rdy = 0;
    int dup = 0;
    do_reset();
    if_req = 1; if_addr = 32'h40; mem_ack = 1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (mem_req) n_req++;
      if (if_ready) n_rdy++;
      if (if_ready && mem_req) dup++;
    end
    if_req = 0; mem_ack = 0;
    checks++;
    if (n_req !== 7) begin errors++; $display("FAIL held_grants: got %0d want 7", n_req); end
    checks++;
    if (n_rdy !== 7) begin errors++; $display("FAIL held_readies: got %0d want 7", n_rdy); end
    checks++;
    if (dup !== 0) begin errors++; $display("FAIL held_overlap: got %0d want 0", dup); end
  endtask

  task automatic test_timeout();
    int cyc = 0;
    do_reset();
    ls_req = 1; ls_we = 0; ls_addr = 32'h500; mem_rdata = 32'hAAAA5555;
    @(negedge clk);
    ls_req = 0;
    while (mem_req && cyc < 400) begin
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (cyc !== 255) begin errors++; $display("FAIL tmo_cycles: got %0d want 255", cyc); end
    checks++;
    if ({err, ls_ready, if_ready, mem_req, ls_rdata} !== {4'b1100, 32'h0}) begin
      errors++; $display("FAIL tmo_abort: got err=%b lsr=%b ifr=%b req=%b rdata=%h want 1 1 0 0 00000000",
                         err, ls_ready, if_ready, mem_req, ls_rdata);
    end
    @(negedge clk);
    checks++;
    if ({err, ls_ready} !== 2'b00) begin errors++; $display("FAIL tmo_pulse: got %b want 00", {err, ls_ready}); end
    if_req = 1; if_addr = 32'h60;
    @(negedge clk);
    if_req = 0;
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h60}) begin
      errors++; $display("FAIL tmo_idle: got req=%b addr=%h want 1 00000060", mem_req, mem_addr);
    end
    mem_ack = 1;
    @(negedge clk);
    mem_ack = 0;
  endtask

  task automatic test_reset_mid();
    int rdy = 0;
    do_reset();
    ls_req = 1; ls_we = 1; ls_addr = 32'h700; ls_wdata = 32'h55;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: got %b want 1", mem_req); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mid_async: got %b want 0", mem_req); end
    ls_req = 0; mem_ack = 1;
    repeat (2) begin
      @(negedge clk);
      if (ls_ready || if_ready) rdy++;
    end
    reset = 1'b1; mem_ack = 0;
    if_req = 1; if_addr = 32'h44;
    @(negedge clk);
    if (ls_ready || if_ready) rdy++;
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h44}) begin
      errors++; $display("FAIL rst_mid_grant: got req=%b addr=%h want 1 00000044", mem_req, mem_addr);
    end
    checks++;
    if (rdy !== 0) begin errors++; $display("FAIL rst_mid_ready: got %0d pulses want 0", rdy); end
    if_req = 0; mem_ack = 1; mem_rdata = 32'h77;
    @(negedge clk);
    mem_ack = 0;
    checks++;
    if ({if_ready, if_rdata} !== {1'b1, 32'h77}) begin
      errors++; $display("FAIL rst_mid_after: got rdy=%b data=%h want 1 00000077", if_ready, if_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_load();
    test_store();
    test_contention();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
